token_rr_scheduler: RTL and testbench
=====================================

TOKEN_RR_SCHEDULER -- requirements
Module: token_rr_scheduler

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..16).
REQ-002 Parameter DEN, default 16, token units per request.
REQ-003 Parameter RATE_NUM, default 3, token units added per requester per cycle.
REQ-004 Parameter BURST_MAX, default 8, bucket capacity in requests; capacity TOK_MAX = BURST_MAX*DEN.
REQ-005 Parameter TOKEN_COST, default DEN, token units consumed per grant.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 req_i  input  NREQ  per-requester request level; requester holds it until granted.
REQ-009 stall_i  input  1  downstream busy; no grant is issued while high.
REQ-010 grant_o  output  NREQ  registered one-hot grant; at most one bit set.
REQ-011 grant_vld_o  output  1  registered; high when any grant_o bit is set.
REQ-012 grant_id_o  output  clog2(NREQ)  registered index of granted requester; 0 when grant_vld_o low.
REQ-013 eligible_o  output  NREQ  combinational; bit i high when requester i's post-add tokens >= TOKEN_COST.

Function
REQ-014 Each requester i SHALL own a 32-bit token counter tok[i].
REQ-015 Each cycle post-add value add_sat[i] = min(tok[i] + RATE_NUM, TOK_MAX), computed 33-bit wide, no wrap.
REQ-016 Candidate set = requesters with req_i[i]=1 and add_sat[i] >= TOKEN_COST; empty when stall_i=1.
REQ-017 Winner = first candidate found searching round-robin from pointer rr_ptr upward, wrapping NREQ-1 to 0.
REQ-018 On the edge with a winner w: tok[w] <= add_sat[w] - TOKEN_COST; all others tok[i] <= add_sat[i].
REQ-019 With no winner: all tok[i] <= add_sat[i]; accrual continues during stall and idle.
REQ-020 rr_ptr <= (w+1) mod NREQ after a grant; unchanged when no grant (including stall).
REQ-021 grant_o/grant_vld_o/grant_id_o SHALL reflect the decision of the previous cycle (latency 1 from req_i to grant_o).
REQ-022 Requester still asserting req_i after grant is re-arbitrated next cycle like any other; no back-to-back lockout beyond token and RR rules.
REQ-023 Token counters never exceed TOK_MAX and never go below 0.
REQ-024 Requester with req_i=0 SHALL never be granted, regardless of tokens.
REQ-025 eligible_o ignores req_i and stall_i.

Reset
REQ-026 On rst_n low, asynchronously: tok[i]=TOK_MAX for all i, rr_ptr=0, grant_o=0, grant_vld_o=0, grant_id_o=0.
REQ-027 Reset asserted mid-operation SHALL clear grant outputs immediately, without waiting for clk; first possible grant is the first edge after deassertion.

Structure
REQ-028 Shared package token_pkg SHALL hold TOK_MAX computation helper, counter width constant (32) and the default DEN/RATE_NUM/BURST_MAX values.
REQ-029 Per-requester saturating counter with eligibility compare SHALL be a sub-module token_slot, instantiated NREQ times; RR picker and output registers stay in the top.

Verification (NREQ=4, DEN=16, RATE_NUM=3, BURST_MAX=8, TOKEN_COST=16)
REQ-030 All four req_i held high from reset release -> grant_id_o sequence 0,1,2,3,0,... one grant per cycle, first grant_vld_o one cycle after first edge.
REQ-031 Only req_i[2] held high -> 9 consecutive grants, no grant in cycles 10-11, grant in cycle 12 (tok 17->1), next grant in cycle 17.
REQ-032 stall_i high 20 cycles with all requesting -> no grants, rr_ptr unchanged, tokens stay at 128; first grant after stall drop goes to rr_ptr owner.
REQ-033 Requester 1 drained to 0 tokens, all requesting -> requester 1 skipped (eligible_o[1]=0) while 0,2,3 rotate; requester 1 re-enters when add_sat reaches 16.
REQ-034 rst_n pulsed low between edges while grant_vld_o=1 -> grant outputs 0 immediately, all tokens 128, rr_ptr 0 on release.
REQ-035 Random req_i/stall_i 10k cycles -> grant_o always one-hot or zero, never granted without req_i, tokens within [0,128] per scoreboard model.

Source files
------------

// File: rtl/token_pkg.sv
// Shared constants and helpers for the token-bucket round-robin scheduler.
package token_pkg;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned SAT_W = CNT_W + 1;

  localparam int unsigned DEF_DEN       = 16;
  localparam int unsigned DEF_RATE_NUM  = 3;
  localparam int unsigned DEF_BURST_MAX = 8;

  typedef logic [CNT_W-1:0] tok_t;
  typedef logic [SAT_W-1:0] sat_t;

  // Bucket capacity in token units, one bit wider than the counter.
  function automatic sat_t tok_max(input int unsigned burst_max, input int unsigned den);
    return SAT_W'(burst_max) * SAT_W'(den);
  endfunction

endpackage

// File: rtl/token_slot.sv
// One requester's saturating token bucket with eligibility compare.
module token_slot
  import token_pkg::*;
#(
  parameter int unsigned DEN        = DEF_DEN,
  parameter int unsigned RATE_NUM   = DEF_RATE_NUM,
  parameter int unsigned BURST_MAX  = DEF_BURST_MAX,
  parameter int unsigned TOKEN_COST = DEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic consume,
  output logic eligible_c
);

  localparam sat_t TOK_MAX = tok_max(BURST_MAX, DEN);

  tok_t tok;
  sat_t sum;
  sat_t add_sat;

  // Post-accrual value, clamped to capacity; extra bit keeps the add from wrapping.
  always_comb begin
    sum     = {1'b0, tok} + SAT_W'(RATE_NUM);
    add_sat = (sum > TOK_MAX) ? TOK_MAX : sum;
  end

  assign eligible_c = (add_sat >= SAT_W'(TOKEN_COST));

  // consume is only raised when eligible_c is high, so the subtract cannot underflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok <= TOK_MAX[CNT_W-1:0];
    end else if (consume) begin
      tok <= CNT_W'(add_sat - SAT_W'(TOKEN_COST));
    end else begin
      tok <= CNT_W'(add_sat);
    end
  end

endmodule

// File: rtl/token_rr_scheduler.sv
// Token-bucket rate-limited round-robin arbiter with a registered one-hot grant.
module token_rr_scheduler
  import token_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned DEN        = DEF_DEN,
  parameter int unsigned RATE_NUM   = DEF_RATE_NUM,
  parameter int unsigned BURST_MAX  = DEF_BURST_MAX,
  parameter int unsigned TOKEN_COST = DEN
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_i,
  input  logic                      stall_i,
  output logic [NREQ-1:0]           grant_o,
  output logic                      grant_vld_o,
  output logic [$clog2(NREQ)-1:0]   grant_id_o,
  output logic [NREQ-1:0]           eligible_o
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned PW    = IDX_W + 1;

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] ptr_nxt;
  logic [IDX_W-1:0] idx;
  logic [PW-1:0]    pos;
  logic [PW-1:0]    pos_nxt;
  logic [NREQ-1:0]  cand;
  logic [NREQ-1:0]  win_oh;
  logic             win_vld;
  logic [IDX_W-1:0] win_id;

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    token_slot #(
      .DEN        (DEN),
      .RATE_NUM   (RATE_NUM),
      .BURST_MAX  (BURST_MAX),
      .TOKEN_COST (TOKEN_COST)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .consume    (win_oh[i]),
      .eligible_c (eligible_o[i])
    );
  end

  // Round-robin search starting at rr_ptr, wrapping at NREQ (need not be a power of two).
  always_comb begin
    cand    = stall_i ? '0 : (req_i & eligible_o);
    win_vld = 1'b0;
    win_id  = '0;
    win_oh  = '0;
    pos     = '0;
    idx     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = {1'b0, rr_ptr} + PW'(k);
      if (pos >= PW'(NREQ)) pos = pos - PW'(NREQ);
      idx = IDX_W'(pos);
      if (!win_vld && cand[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
    if (win_vld) win_oh[win_id] = 1'b1;
  end

  always_comb begin
    pos_nxt = {1'b0, win_id} + PW'(1);
    ptr_nxt = (pos_nxt >= PW'(NREQ)) ? '0 : IDX_W'(pos_nxt);
  end

  // Grant outputs and pointer; pointer only advances past an actual winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_o     <= '0;
      grant_vld_o <= 1'b0;
      grant_id_o  <= '0;
      rr_ptr      <= '0;
    end else begin
      grant_o     <= win_oh;
      grant_vld_o <= win_vld;
      grant_id_o  <= win_id;
      if (win_vld) rr_ptr <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_token_rr_scheduler.sv
// Directed and model-checked random bench for token_rr_scheduler (4 requesters, default tokens).
module tb_token_rr_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_i;
  logic       stall_i;
  logic [3:0] grant_o;
  logic       grant_vld_o;
  logic [1:0] grant_id_o;
  logic [3:0] eligible_o;

  int n_checks;
  int n_fail;
  int tok_m[4];
  int ptr_m;

  token_rr_scheduler #(
    .NREQ(4), .DEN(16), .RATE_NUM(3), .BURST_MAX(8), .TOKEN_COST(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .stall_i     (stall_i),
    .grant_o     (grant_o),
    .grant_vld_o (grant_vld_o),
    .grant_id_o  (grant_id_o),
    .eligible_o  (eligible_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic s);
    req_i   = r;
    stall_i = s;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req_i   = '0;
    stall_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tok_m[i] = 128;
    ptr_m = 0;
  endtask

  function automatic int add_sat_m(input int t);
    return (t + 3 > 128) ? 128 : t + 3;
  endfunction

  function automatic logic [3:0] model_elig();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = (add_sat_m(tok_m[i]) >= 16);
    return e;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic s,
                            output logic [3:0] eg, output logic [1:0] eid);
    int w;
    int a[4];
    w = -1;
    for (int i = 0; i < 4; i++) a[i] = add_sat_m(tok_m[i]);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (ptr_m + k) % 4;
      if (w < 0 && r[i] && !s && a[i] >= 16) w = i;
    end
    eg  = '0;
    eid = '0;
    for (int i = 0; i < 4; i++) tok_m[i] = (i == w) ? a[i] - 16 : a[i];
    if (w >= 0) begin
      eg[w] = 1'b1;
      eid   = 2'(w);
      ptr_m = (w + 1) % 4;
    end
  endtask

  initial begin
    logic [3:0] eg;
    logic [1:0] eid;
    logic [3:0] rr;
    logic       ss;
    logic       exp_g;
    int         ids4[7];
    int         el4[7];

    n_checks = 0;
    n_fail   = 0;

    // All requesters: plain rotation from 0
    do_reset();
    check("rst_vld", grant_vld_o, 0);
    check("rst_grant", grant_o, 0);
    check("rst_id", grant_id_o, 0);
    drive(4'hF, 1'b0);
    check("t1_elig", eligible_o, 4'hF);
    for (int c = 0; c < 8; c++) begin
      tick();
      check("t1_vld", grant_vld_o, 1);
      check("t1_id", grant_id_o, c % 4);
      check("t1_oh", grant_o, 32'(1) << (c % 4));
    end

    // Single requester drains its burst, then rate-limited
    do_reset();
    drive(4'b0100, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      exp_g = ((c >= 1 && c <= 9) || c == 12 || c == 17);
      check("t2_elig", eligible_o[2], exp_g);
      tick();
      check("t2_vld", grant_vld_o, exp_g);
      check("t2_id", grant_id_o, exp_g ? 2 : 0);
    end

    // Stall holds pointer; tokens refill
    do_reset();
    drive(4'hF, 1'b0);
    tick();
    tick();
    check("t3_pre_id", grant_id_o, 1);
    drive(4'hF, 1'b1);
    for (int c = 0; c < 20; c++) begin
      tick();
      check("t3_stall_vld", grant_vld_o, 0);
      check("t3_stall_oh", grant_o, 0);
    end
    check("t3_elig", eligible_o, 4'hF);
    drive(4'hF, 1'b0);
    tick();
    check("t3_post_vld", grant_vld_o, 1);
    check("t3_post_id", grant_id_o, 2);

    // Requester 1 drained to zero is skipped until refilled
    do_reset();
    drive(4'b0010, 1'b0);
    for (int c = 0; c < 17; c++) tick();
    ids4 = '{2, 3, 0, 2, 3, 0, 1};
    el4  = '{0, 0, 0, 0, 0, 1, 1};
    drive(4'hF, 1'b0);
    check("t4_elig_all", eligible_o, 4'b1101);
    for (int c = 0; c < 7; c++) begin
      check("t4_elig1", eligible_o[1], el4[c]);
      tick();
      check("t4_id", grant_id_o, ids4[c]);
      check("t4_vld", grant_vld_o, 1);
    end

    // Asynchronous reset between edges
    do_reset();
    drive(4'hF, 1'b0);
    tick();
    tick();
    check("t5_pre_id", grant_id_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_vld", grant_vld_o, 0);
    check("t5_async_oh", grant_o, 0);
    check("t5_async_id", grant_id_o, 0);
    tick();
    check("t5_hold_vld", grant_vld_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'hF, 1'b0);
    check("t5_elig", eligible_o, 4'hF);
    tick();
    check("t5_first_id", grant_id_o, 0);
    check("t5_first_vld", grant_vld_o, 1);
    tick();
    check("t5_second_id", grant_id_o, 1);

    // Random traffic against the reference model
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      rr = 4'($urandom_range(0, 15));
      ss = ($urandom_range(0, 3) == 0);
      drive(rr, ss);
      check("rnd_elig", eligible_o, model_elig());
      model_step(rr, ss, eg, eid);
      tick();
      check("rnd_grant", grant_o, eg);
      check("rnd_id", grant_id_o, eid);
      check("rnd_vld", grant_vld_o, |eg);
      check("rnd_noreq", grant_o & ~rr, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
